reorder_buffer: RTL
===================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_WIDTH, default 4, meaning index width; index 0 means "no dependency" and is never allocated, so capacity is 2^ROB_WIDTH-1 entries.
REQ-002 SHALL have ports clk_in input 1 clock; rst_in input 1 synchronous active-high reset; rdy_in input 1 global enable.
REQ-003 SHALL have ports issue_ready input 1 allocate strobe; issue_rd_id input 5; issue_opcode input 7; issue_pc input 32; issue_prediction input 1 predicted taken.
REQ-004 SHALL have ports rob_full output 1; rob_new_idx output ROB_WIDTH, the index the next issue receives.
REQ-005 SHALL have ports iu_to_rob_rs1_depend and iu_to_rob_rs2_depend input ROB_WIDTH; rob_to_iu_rs1_ready and rob_to_iu_rs2_ready output 1; rob_to_iu_val1 and rob_to_iu_val2 output 32.
REQ-006 SHALL have ports rs_ready input 1; rs_rob_idx input ROB_WIDTH; rs_val input 32; rs_actual_br input 1; rs_pc_jump input 32 correct next PC; lsb_ready input 1; lsb_rob_idx input ROB_WIDTH; lsb_val input 32.
REQ-007 SHALL have ports commit_valid output 1; commit_rd_id output 5; commit_val output 32; commit_rob_idx output ROB_WIDTH; commit_store output 1; clr_out output 1; clr_pc output 32; bp_update_valid output 1; bp_update_pc output 32; bp_update_taken output 1.

Function
REQ-008 SHALL be a circular FIFO over indices 1..2^ROB_WIDTH-1; head/tail advance from the last index to 1, skipping 0.
REQ-009 SHALL on issue_ready with rdy_in and not rob_full write entry at tail (busy=1, ready=0, rd, opcode, pc, prediction) and advance tail; issue while rob_full SHALL be ignored.
REQ-010 SHALL drive rob_new_idx = tail and rob_full = (count == capacity) combinationally from registered state.
REQ-011 SHALL on rs_ready or lsb_ready mark the addressed busy entry ready and latch val (and actual_br, pc_jump for rs); both buses in one cycle to distinct entries SHALL both be captured; writes to non-busy entries ignored.
REQ-012 SHALL answer rsN lookups combinationally: ready = entry busy and ready, val = entry val; depend 0 returns ready=0, val=0.
REQ-013 SHALL commit at most one entry per cycle: when head entry is busy and ready, next cycle pulse commit_valid for one cycle with its rd, val, index, then free it and advance head.
REQ-014 SHALL set commit_rd_id=0 for opcodes B and S; commit_store=1 only for opcode S.
REQ-015 SHALL for opcode B pulse bp_update_valid with bp_update_pc=pc, bp_update_taken=actual_br.
REQ-016 SHALL flag mispredict when opcode B and actual_br != prediction, or opcode JALR; on committing it, pulse clr_out one cycle with clr_pc=pc_jump.
REQ-017 SHALL in the cycle after clr_out assert, hold all entries invalid, head=tail=1, count=0, and ignore issue and CDB writes during the clr_out cycle.
REQ-018 SHALL handle simultaneous issue and commit at one count, leaving count unchanged.
REQ-019 SHALL with rdy_in low hold all state and drive commit_valid, clr_out, bp_update_valid low.

Reset
REQ-020 SHALL on rst_in clear all busy/ready bits, set head=tail=1, count=0.
REQ-021 SHALL on rst_in drive commit_valid, commit_store, clr_out, bp_update_valid, bp_update_taken to 0 and commit_rd_id, commit_val, commit_rob_idx, clr_pc, bp_update_pc to 0; reset mid-flush overrides flush.

Configuration
REQ-022 SHALL with ROB_BYPASS_EN defined forward a same-cycle rs/lsb CDB write matching rsN depend into the lookup (ready=1, val=bus val; rs wins over lsb on a tie) and allow commit in the same cycle as CDB arrival; without it lookups and commit see only registered entry state, one cycle later.

Verification
REQ-023 Reset then issue 3 ALU ops rd=1,2,3 -> rob_new_idx 1,2,3,4 and rob_full=0.
REQ-024 Fill 2^W-1=15 entries -> rob_full=1, 16th issue ignored, tail wraps to 1 after a commit.
REQ-025 Complete idx 2 then idx 1 via rs (vals 0x22, 0x11) -> commits in order: idx1 rd1 0x11, then idx2 rd2 0x22.
REQ-026 Branch pc=0x100 predicted 0, rs_actual_br=1, rs_pc_jump=0x140 -> bp_update pc 0x100 taken 1, clr_out=1, clr_pc=0x140, next cycle rob_new_idx=1, count 0.
REQ-027 Lookup depend=3 in the cycle lsb_ready writes idx3 with 0x55 -> with ROB_BYPASS_EN ready=1 val=0x55; without, ready=0 that cycle, 1 the next.
REQ-028 Store at head completes -> commit_store=1, commit_rd_id=0; rdy_in low meanwhile -> commit deferred until rdy_in returns.

Source files
------------

// File: rtl/reorder_buffer_if.sv
// Issue, operand-lookup, CDB, commit and flush signals of the reorder buffer.
// master = pipeline side driving the ROB, slave = the ROB itself.
interface reorder_buffer_if #(
  parameter int unsigned ROB_WIDTH = 4
);
  logic                 issue_ready;
  logic [4:0]           issue_rd_id;
  logic [6:0]           issue_opcode;
  logic [31:0]          issue_pc;
  logic                 issue_prediction;
  logic                 rob_full;
  logic [ROB_WIDTH-1:0] rob_new_idx;

  logic [ROB_WIDTH-1:0] iu_to_rob_rs1_depend;
  logic [ROB_WIDTH-1:0] iu_to_rob_rs2_depend;
  logic                 rob_to_iu_rs1_ready;
  logic                 rob_to_iu_rs2_ready;
  logic [31:0]          rob_to_iu_val1;
  logic [31:0]          rob_to_iu_val2;

  logic                 rs_ready;
  logic [ROB_WIDTH-1:0] rs_rob_idx;
  logic [31:0]          rs_val;
  logic                 rs_actual_br;
  logic [31:0]          rs_pc_jump;
  logic                 lsb_ready;
  logic [ROB_WIDTH-1:0] lsb_rob_idx;
  logic [31:0]          lsb_val;

  logic                 commit_valid;
  logic [4:0]           commit_rd_id;
  logic [31:0]          commit_val;
  logic [ROB_WIDTH-1:0] commit_rob_idx;
  logic                 commit_store;
  logic                 clr_out;
  logic [31:0]          clr_pc;
  logic                 bp_update_valid;
  logic [31:0]          bp_update_pc;
  logic                 bp_update_taken;

  modport master (
    output issue_ready, issue_rd_id, issue_opcode, issue_pc, issue_prediction,
    output iu_to_rob_rs1_depend, iu_to_rob_rs2_depend,
    output rs_ready, rs_rob_idx, rs_val, rs_actual_br, rs_pc_jump,
    output lsb_ready, lsb_rob_idx, lsb_val,
    input  rob_full, rob_new_idx,
    input  rob_to_iu_rs1_ready, rob_to_iu_rs2_ready, rob_to_iu_val1, rob_to_iu_val2,
    input  commit_valid, commit_rd_id, commit_val, commit_rob_idx, commit_store,
    input  clr_out, clr_pc, bp_update_valid, bp_update_pc, bp_update_taken
  );

  modport slave (
    input  issue_ready, issue_rd_id, issue_opcode, issue_pc, issue_prediction,
    input  iu_to_rob_rs1_depend, iu_to_rob_rs2_depend,
    input  rs_ready, rs_rob_idx, rs_val, rs_actual_br, rs_pc_jump,
    input  lsb_ready, lsb_rob_idx, lsb_val,
    output rob_full, rob_new_idx,
    output rob_to_iu_rs1_ready, rob_to_iu_rs2_ready, rob_to_iu_val1, rob_to_iu_val2,
    output commit_valid, commit_rd_id, commit_val, commit_rob_idx, commit_store,
    output clr_out, clr_pc, bp_update_valid, bp_update_pc, bp_update_taken
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order-commit reorder buffer over indices 1..2^ROB_WIDTH-1 (index 0 = no dependency).
// Define ROB_BYPASS_EN to forward same-cycle CDB writes into lookups and head commit.
module reorder_buffer #(
  parameter int unsigned ROB_WIDTH = 4
) (
  input logic             clk_in,
  input logic             rst_in,
  input logic             rdy_in,
  reorder_buffer_if.slave rob_if
);
  localparam int unsigned DEPTH = 1 << ROB_WIDTH;
  localparam int unsigned CAP   = DEPTH - 1;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;

  typedef logic [ROB_WIDTH-1:0] idx_t;

  logic [DEPTH-1:0] busy_q, ready_q;
  logic [4:0]       rd_q   [DEPTH];
  logic [6:0]       op_q   [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic             pred_q [DEPTH];
  logic [31:0]      val_q  [DEPTH];
  logic             br_q   [DEPTH];
  logic [31:0]      jump_q [DEPTH];
  idx_t             head_q, tail_q, count_q;

  logic             commit_valid_q, commit_store_q, clr_out_q;
  logic             bp_update_valid_q, bp_update_taken_q;
  logic [4:0]       commit_rd_id_q;
  logic [31:0]      commit_val_q, clr_pc_q, bp_update_pc_q;
  idx_t             commit_rob_idx_q;

  logic             full_c, active_c, issue_c, rs_wr_c, lsb_wr_c, commit_c;
  logic             head_ready_c, head_br_c, mispredict_c;
  logic [31:0]      head_val_c, head_jump_c;
  idx_t             dep_c     [2];
  logic             lk_rdy_c  [2];
  logic [31:0]      lk_val_c  [2];

  function automatic idx_t next_idx(input idx_t i);
    return (i == idx_t'(CAP)) ? idx_t'(1) : i + idx_t'(1);
  endfunction

  // The clr_out cycle is dead time: no issue, CDB write or commit is accepted.
  assign full_c   = (count_q == idx_t'(CAP));
  assign active_c = rdy_in && !clr_out_q;
  assign issue_c  = active_c && rob_if.issue_ready && !full_c;
  assign rs_wr_c  = active_c && rob_if.rs_ready  && busy_q[rob_if.rs_rob_idx];
  assign lsb_wr_c = active_c && rob_if.lsb_ready && busy_q[rob_if.lsb_rob_idx];

`ifdef ROB_BYPASS_EN
  logic rs_hit_c, lsb_hit_c;
  assign rs_hit_c     = rs_wr_c  && (rob_if.rs_rob_idx  == head_q);
  assign lsb_hit_c    = lsb_wr_c && (rob_if.lsb_rob_idx == head_q);
  assign head_ready_c = ready_q[head_q] || rs_hit_c || lsb_hit_c;
  assign head_val_c   = ready_q[head_q] ? val_q[head_q]  : (rs_hit_c ? rob_if.rs_val : rob_if.lsb_val);
  assign head_br_c    = ready_q[head_q] ? br_q[head_q]   : (rs_hit_c && rob_if.rs_actual_br);
  assign head_jump_c  = ready_q[head_q] ? jump_q[head_q] : (rs_hit_c ? rob_if.rs_pc_jump : 32'h0);
`else
  assign head_ready_c = ready_q[head_q];
  assign head_val_c   = val_q[head_q];
  assign head_br_c    = br_q[head_q];
  assign head_jump_c  = jump_q[head_q];
`endif

  assign commit_c     = active_c && busy_q[head_q] && head_ready_c;
  assign mispredict_c = ((op_q[head_q] == OP_BRANCH) && (head_br_c != pred_q[head_q])) ||
                        (op_q[head_q] == OP_JALR);

  assign dep_c[0] = rob_if.iu_to_rob_rs1_depend;
  assign dep_c[1] = rob_if.iu_to_rob_rs2_depend;

  // Operand lookups; rs bus is checked last so it wins a tie with lsb.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      lk_rdy_c[p] = 1'b0;
      lk_val_c[p] = 32'h0;
      if (dep_c[p] != '0) begin
        if (busy_q[dep_c[p]] && ready_q[dep_c[p]]) begin
          lk_rdy_c[p] = 1'b1;
          lk_val_c[p] = val_q[dep_c[p]];
        end
`ifdef ROB_BYPASS_EN
        if (lsb_wr_c && (rob_if.lsb_rob_idx == dep_c[p])) begin
          lk_rdy_c[p] = 1'b1;
          lk_val_c[p] = rob_if.lsb_val;
        end
        if (rs_wr_c && (rob_if.rs_rob_idx == dep_c[p])) begin
          lk_rdy_c[p] = 1'b1;
          lk_val_c[p] = rob_if.rs_val;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q            <= '0;
      ready_q           <= '0;
      head_q            <= idx_t'(1);
      tail_q            <= idx_t'(1);
      count_q           <= '0;
      commit_valid_q    <= 1'b0;
      commit_store_q    <= 1'b0;
      clr_out_q         <= 1'b0;
      bp_update_valid_q <= 1'b0;
      bp_update_taken_q <= 1'b0;
      commit_rd_id_q    <= '0;
      commit_val_q      <= '0;
      commit_rob_idx_q  <= '0;
      clr_pc_q          <= '0;
      bp_update_pc_q    <= '0;
    end else begin
      commit_valid_q    <= 1'b0;
      commit_store_q    <= 1'b0;
      clr_out_q         <= 1'b0;
      bp_update_valid_q <= 1'b0;
      if (clr_out_q) begin
        busy_q  <= '0;
        ready_q <= '0;
        head_q  <= idx_t'(1);
        tail_q  <= idx_t'(1);
        count_q <= '0;
      end else if (rdy_in) begin
        if (rs_wr_c) begin
          ready_q[rob_if.rs_rob_idx] <= 1'b1;
          val_q[rob_if.rs_rob_idx]   <= rob_if.rs_val;
          br_q[rob_if.rs_rob_idx]    <= rob_if.rs_actual_br;
          jump_q[rob_if.rs_rob_idx]  <= rob_if.rs_pc_jump;
        end
        if (lsb_wr_c) begin
          ready_q[rob_if.lsb_rob_idx] <= 1'b1;
          val_q[rob_if.lsb_rob_idx]   <= rob_if.lsb_val;
        end
        if (issue_c) begin
          busy_q[tail_q]  <= 1'b1;
          ready_q[tail_q] <= 1'b0;
          rd_q[tail_q]    <= rob_if.issue_rd_id;
          op_q[tail_q]    <= rob_if.issue_opcode;
          pc_q[tail_q]    <= rob_if.issue_pc;
          pred_q[tail_q]  <= rob_if.issue_prediction;
          tail_q          <= next_idx(tail_q);
        end
        // Freeing the head comes after the CDB writes so a bypassed hit cannot revive it.
        if (commit_c) begin
          busy_q[head_q]   <= 1'b0;
          ready_q[head_q]  <= 1'b0;
          head_q           <= next_idx(head_q);
          commit_valid_q   <= 1'b1;
          commit_rob_idx_q <= head_q;
          commit_val_q     <= head_val_c;
          commit_store_q   <= (op_q[head_q] == OP_STORE);
          commit_rd_id_q   <= ((op_q[head_q] == OP_STORE) || (op_q[head_q] == OP_BRANCH))
                              ? 5'd0 : rd_q[head_q];
          if (op_q[head_q] == OP_BRANCH) begin
            bp_update_valid_q <= 1'b1;
            bp_update_pc_q    <= pc_q[head_q];
            bp_update_taken_q <= head_br_c;
          end
          if (mispredict_c) begin
            clr_out_q <= 1'b1;
            clr_pc_q  <= head_jump_c;
          end
        end
        count_q <= count_q + idx_t'(issue_c) - idx_t'(commit_c);
      end
    end
  end

  assign rob_if.rob_full            = full_c;
  assign rob_if.rob_new_idx         = tail_q;
  assign rob_if.rob_to_iu_rs1_ready = lk_rdy_c[0];
  assign rob_if.rob_to_iu_rs2_ready = lk_rdy_c[1];
  assign rob_if.rob_to_iu_val1      = lk_val_c[0];
  assign rob_if.rob_to_iu_val2      = lk_val_c[1];
  assign rob_if.commit_valid        = commit_valid_q;
  assign rob_if.commit_rd_id        = commit_rd_id_q;
  assign rob_if.commit_val          = commit_val_q;
  assign rob_if.commit_rob_idx      = commit_rob_idx_q;
  assign rob_if.commit_store        = commit_store_q;
  assign rob_if.clr_out             = clr_out_q;
  assign rob_if.clr_pc              = clr_pc_q;
  assign rob_if.bp_update_valid     = bp_update_valid_q;
  assign rob_if.bp_update_pc        = bp_update_pc_q;
  assign rob_if.bp_update_taken     = bp_update_taken_q;
endmodule
